// File: rtl/demux_1_4_load.sv
// demux_1_4_load: 1-to-4 load distributor.
// Accepts WIDTH-bit words over a valid/ready handshake and writes each one
// into one of four registered lanes. The lane is chosen by an explicit select
// or by an auto-incrementing pointer. Reports per-lane occupancy, and pulses
// all_loaded for one cycle when the last empty lane is filled.
module demux_1_4_load #(
    parameter int unsigned WIDTH = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             auto_mode,
    input  logic             clear,
    output logic [WIDTH-1:0] K0,
    output logic [WIDTH-1:0] K1,
    output logic [WIDTH-1:0] K2,
    output logic [WIDTH-1:0] K3,
    output logic [3:0]       lane_valid,
    output logic [1:0]       ptr,
    output logic             all_loaded
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] k_q [4];
    logic [3:0]       lane_valid_q;
    logic [3:0]       lane_valid_d;
    logic [1:0]       ptr_q;
    logic             all_loaded_q;

    logic             transfer;
    logic [1:0]       target;

    // Handshake decode and target lane selection for the current cycle
    always_comb begin
        in_ready     = (state_q != FULL);
        transfer     = in_valid && in_ready;
        target       = auto_mode ? ptr_q : in_sel;
        lane_valid_d = lane_valid_q | (4'b0001 << target);
    end

    // Lane registers, occupancy, pointer, fill-state FSM and all_loaded pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            lane_valid_q <= '0;
            ptr_q        <= '0;
            all_loaded_q <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                k_q[i] <= '0;
            end
        end else if (clear) begin
            // Clear wins over a simultaneous transfer; that word is dropped.
            state_q      <= EMPTY;
            lane_valid_q <= '0;
            ptr_q        <= '0;
            all_loaded_q <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                k_q[i] <= '0;
            end
        end else if (transfer) begin
            k_q[target]  <= in_data;
            lane_valid_q <= lane_valid_d;
            if (auto_mode) begin
                ptr_q <= ptr_q + 2'd1;
            end
            if (lane_valid_d == 4'b1111) begin
                state_q      <= FULL;
                all_loaded_q <= 1'b1;
            end else begin
                state_q      <= FILLING;
                all_loaded_q <= 1'b0;
            end
        end else begin
            all_loaded_q <= 1'b0;
        end
    end

    // Drive outputs directly from registers
    always_comb begin
        K0         = k_q[0];
        K1         = k_q[1];
        K2         = k_q[2];
        K3         = k_q[3];
        lane_valid = lane_valid_q;
        ptr        = ptr_q;
        all_loaded = all_loaded_q;
    end

endmodule

// File: tb/tb_demux_1_4_load.sv
// Directed testbench for demux_1_4_load with hand-computed expectations.
module tb_demux_1_4_load;

    localparam int unsigned WIDTH = 28;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             auto_mode;
    logic             clear;
    logic [WIDTH-1:0] K0, K1, K2, K3;
    logic [3:0]       lane_valid;
    logic [1:0]       ptr;
    logic             all_loaded;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    demux_1_4_load #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .auto_mode  (auto_mode),
        .clear      (clear),
        .K0         (K0),
        .K1         (K1),
        .K2         (K2),
        .K3         (K3),
        .lane_valid (lane_valid),
        .ptr        (ptr),
        .all_loaded (all_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_lanes(input string tag, input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                               input logic [WIDTH-1:0] e2, input logic [WIDTH-1:0] e3);
        check({tag, ".K0"}, 32'(K0), 32'(e0));
        check({tag, ".K1"}, 32'(K1), 32'(e1));
        check({tag, ".K2"}, 32'(K2), 32'(e2));
        check({tag, ".K3"}, 32'(K3), 32'(e3));
    endtask

    task automatic check_ctl(input string tag, input logic [3:0] lv, input logic [1:0] p,
                             input logic rdy, input logic al);
        check({tag, ".lane_valid"}, 32'(lane_valid), 32'(lv));
        check({tag, ".ptr"},        32'(ptr),        32'(p));
        check({tag, ".in_ready"},   32'(in_ready),   32'(rdy));
        check({tag, ".all_loaded"}, 32'(all_loaded), 32'(al));
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        auto_mode = 1'b0;
        clear     = 1'b0;
        step();
        step();
        check_lanes("reset", '0, '0, '0, '0);
        check_ctl("reset", 4'b0000, 2'd0, 1'b1, 1'b0);
        rst_n = 1'b1;

        // Load one word, then assert reset mid-cycle: must clear immediately
        in_valid = 1'b1; in_sel = 2'd1; in_data = 28'h5555555;
        step();
        in_valid = 1'b0;
        check_lanes("pre_rst", '0, 28'h5555555, '0, '0);
        check_ctl("pre_rst", 4'b0010, 2'd0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_lanes("async_rst", '0, '0, '0, '0);
        check_ctl("async_rst", 4'b0000, 2'd0, 1'b1, 1'b0);
        step();
        rst_n = 1'b1;
        repeat (5) step();
        check_lanes("idle", '0, '0, '0, '0);
        check_ctl("idle", 4'b0000, 2'd0, 1'b1, 1'b0);

        // Auto fill, back-to-back
        auto_mode = 1'b1; in_valid = 1'b1;
        in_data = 28'hAAAAAAA; step();
        check_ctl("auto1", 4'b0001, 2'd1, 1'b1, 1'b0);
        check("auto1.K0", 32'(K0), 32'h0AAAAAAA);
        in_data = 28'hBBBBBBB; step();
        check_ctl("auto2", 4'b0011, 2'd2, 1'b1, 1'b0);
        in_data = 28'hCCCCCCC; step();
        check_ctl("auto3", 4'b0111, 2'd3, 1'b1, 1'b0);
        in_data = 28'hDDDDDDD; step();
        check_ctl("auto4", 4'b1111, 2'd0, 1'b0, 1'b1);
        check_lanes("auto4", 28'hAAAAAAA, 28'hBBBBBBB, 28'hCCCCCCC, 28'hDDDDDDD);

        // Backpressure while FULL: word held, nothing changes
        in_data = 28'hFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check_ctl("full_hold", 4'b1111, 2'd0, 1'b0, 1'b0);
            check_lanes("full_hold", 28'hAAAAAAA, 28'hBBBBBBB, 28'hCCCCCCC, 28'hDDDDDDD);
        end
        clear = 1'b1; step();
        clear = 1'b0;
        check_lanes("full_clear", '0, '0, '0, '0);
        check_ctl("full_clear", 4'b0000, 2'd0, 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        check_lanes("pending", 28'hFFFFFFF, '0, '0, '0);
        check_ctl("pending", 4'b0001, 2'd1, 1'b1, 1'b0);

        // Clear collides with a transfer in FILLING (ptr = 1): word dropped
        clear = 1'b1; in_valid = 1'b1; in_data = 28'h0000042; step();
        clear = 1'b0; in_valid = 1'b0;
        check_lanes("collide", '0, '0, '0, '0);
        check_ctl("collide", 4'b0000, 2'd0, 1'b1, 1'b0);
        step();
        check_lanes("collide_after", '0, '0, '0, '0);

        // Manual write and overwrite to lane 2
        auto_mode = 1'b0; in_sel = 2'd2; in_valid = 1'b1;
        in_data = 28'h1234567; step();
        check("man1.K2", 32'(K2), 32'h01234567);
        in_data = 28'h7654321; step();
        in_valid = 1'b0;
        check_lanes("overwrite", '0, '0, 28'h7654321, '0);
        check_ctl("overwrite", 4'b0100, 2'd0, 1'b1, 1'b0);

        clear = 1'b1; step();
        clear = 1'b0;

        // Mixed modes: auto 0, auto 1, manual 3, then auto lands in lane 2
        in_valid = 1'b1; auto_mode = 1'b1;
        in_data = 28'h0000011; step();
        in_data = 28'h0000022; step();
        auto_mode = 1'b0; in_sel = 2'd3; in_data = 28'h0000033; step();
        check_ctl("mixed3", 4'b1011, 2'd2, 1'b1, 1'b0);
        auto_mode = 1'b1; in_sel = 2'd0; in_data = 28'h0000044; step();
        in_valid = 1'b0;
        check_lanes("mixed4", 28'h0000011, 28'h0000022, 28'h0000044, 28'h0000033);
        check_ctl("mixed4", 4'b1111, 2'd3, 1'b0, 1'b1);
        step();
        check("mixed_pulse_end", 32'(all_loaded), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_1_4_load.md
# demux_1_4_load

Sequential 1-to-4 load distributor: accepts a stream of 28-bit words over a valid/ready handshake and steers each one into one of four registered 28-bit output lanes, K0..K3. It is the write-side counterpart of the 4:1 28-bit lane selector. It fills the four lanes that the selector later reads, either by explicit lane select or by an auto-incrementing pointer. It reports per-lane occupancy and a one-cycle "all loaded" pulse.

## Interface
- WIDTH, 28, data width of the input word and of each lane.
- Lane count is fixed at 4. The select and pointer are 2 bits.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer has a word on in_data.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WIDTH  word to load.
- in_sel  in  2  target lane in manual mode (0..3).
- auto_mode  in  1  1 = target lane is ptr; 0 = target lane is in_sel.
- clear  in  1  synchronous flush of all lanes and state.
- K0, K1, K2, K3  out  WIDTH each  registered lane contents.
- lane_valid  out  4  bit n = 1 when lane n holds a loaded word.
- ptr  out  2  auto-mode write pointer.
- all_loaded  out  1  one-cycle pulse on the transfer that completes the lane set.

## Operation
- Transfer: occurs when in_valid && in_ready at a rising edge.
- Target lane: ptr when auto_mode = 1, in_sel when auto_mode = 0. auto_mode and in_sel are sampled on the transfer cycle only.
- On a transfer:
  - K[target] <= in_data.
  - lane_valid[target] <= 1.
  - In auto mode, ptr <= ptr + 1 (mod 4, so 3 wraps to 0). In manual mode ptr is unchanged.
- Overwrite: a manual transfer to a lane that is already valid replaces its data. lane_valid is unchanged and no error is raised.
- FSM states:
  - EMPTY: lane_valid == 0.
  - FILLING: some lanes are valid.
  - FULL: lane_valid == 4'b1111.
- FSM transitions:
  - EMPTY -> FILLING on the first transfer.
  - FILLING -> FULL on the transfer that sets the last clear bit.
  - Any state -> EMPTY on clear.
- in_ready = 1 in EMPTY and FILLING, 0 in FULL. It is a combinational decode of state only; it does not depend on in_valid.
- all_loaded is registered. It is 1 exactly in the cycle after the transfer that enters FULL, otherwise 0.
- clear, when sampled high:
  - K0..K3 <= 0, lane_valid <= 0, ptr <= 0, state <= EMPTY, all_loaded <= 0.
  - clear has priority over a simultaneous transfer. That word is dropped, even though the producer saw in_ready = 1.
- Mixed modes are legal. ptr advances only on auto-mode transfers, and it is not reset by manual transfers.

## Timing
- Reset (rst_n low, asynchronous): K0..K3 = 0, lane_valid = 0, ptr = 0, all_loaded = 0, state = EMPTY, in_ready = 1.
- Lane write latency: 1 cycle. The new word appears on K[target] and lane_valid[target] in the cycle after the transfer edge.
- Throughput: one word per cycle while not FULL. Four back-to-back auto transfers reach FULL in 4 cycles.
- in_ready falls in the cycle after the completing transfer, which is the same cycle all_loaded pulses.
- A word offered while in FULL is not accepted and is held by the producer.
- rst_n asserted mid-fill discards everything immediately. The first edge after release behaves as EMPTY.
- Outputs are stable between transfers. No combinational path runs from in_data to K0..K3.

## Test plan
- Reset: assert rst_n = 0 mid-cycle -> all outputs 0 immediately, in_ready = 1. Release, then hold in_valid = 0 for 5 cycles -> no change.
- Auto fill: auto_mode = 1, send 0xAAAAAAA, 0xBBBBBBB, 0xCCCCCCC, 0xDDDDDDD back-to-back -> K0..K3 equal those words in order, and lane_valid steps 0001, 0011, 0111, 1111. all_loaded pulses once in cycle 4, in_ready = 0 from cycle 4, and ptr wraps to 0.
- Manual and overwrite: auto_mode = 0, write in_sel = 2 with 0x1234567, then in_sel = 2 with 0x7654321 -> K2 = 0x7654321, lane_valid = 0100, state still FILLING, ptr = 0.
- Backpressure in FULL: after a full load, hold in_valid = 1 with 0xFFFFFFF for 3 cycles -> no lane changes and in_ready stays 0. Assert clear -> all lanes 0, lane_valid = 0, in_ready = 1, then the pending word loads into K0.
- Clear vs. transfer collision: in FILLING with ptr = 1, assert clear and a valid transfer of 0x0000042 in the same cycle -> next cycle everything is 0, ptr = 0, and the word is not written.
- Mixed modes: auto writes to lanes 0 and 1, manual write to lane 3, then an auto write -> it lands in lane 2 (ptr = 2). lane_valid = 1111 and all_loaded pulses.
